// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubble, taken-branch squash and multi-cycle EX freeze.
// Define HAZARD_PERF_EN to add saturating StallCycles/FlushEvents/MulCycles counters.
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic [4:0] IDRsReg,
   input  logic [4:0] IDRtReg,
   input  logic       IDUsesRs,
   input  logic       IDUsesRt,
   input  logic       EXMemRead,
   input  logic [4:0] EXRtReg,
   input  logic       EXBranchTaken,
   input  logic       EXMultiCycle,
   output logic       PCWrite,
   output logic       IFIDWrite,
   output logic       IFIDFlush,
   output logic       IDEXWrite,
   output logic       IDEXFlush,
   output logic       EXMEMFlush,
`ifdef HAZARD_PERF_EN
   output logic [15:0] StallCycles,
   output logic [15:0] FlushEvents,
   output logic [15:0] MulCycles,
`endif
   output logic       Busy
);

   typedef enum logic {IDLE, MUL_BUSY} state_t;

   // The entry cycle counts toward MUL_LAT, so the counter is loaded with MUL_LAT-2.
   localparam bit               MUL_EN   = (MUL_LAT > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_EN ? MUL_LAT - 2 : 0);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               load_use, branch_flush, mul_entry;

   assign load_use = EXMemRead && (EXRtReg != 5'd0) &&
                     ((IDUsesRs && (IDRsReg == EXRtReg)) ||
                      (IDUsesRt && (IDRtReg == EXRtReg)));

   assign branch_flush = (state_q == IDLE) && EXBranchTaken;
   assign mul_entry    = (state_q == IDLE) && !EXBranchTaken && EXMultiCycle && MUL_EN;

   // NOTE: every output gets a default before the priority chain, so no latch is inferred.
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXWrite  = 1'b1;
      IDEXFlush  = 1'b0;
      EXMEMFlush = 1'b0;
      Busy       = 1'b0;
      if (Reset) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
         EXMEMFlush = 1'b1;
      end else if (state_q == MUL_BUSY || mul_entry) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMFlush = 1'b1;
         Busy       = (state_q == MUL_BUSY);
      end else if (branch_flush) begin
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
      end else if (load_use) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXFlush  = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (mul_entry) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_LOAD;
         end
      end else if (cnt_q == '0) begin
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_q, flush_q, mul_q;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         stall_q <= '0;
         flush_q <= '0;
         mul_q   <= '0;
      end else begin
         if (!PCWrite && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (branch_flush && flush_q != 16'hFFFF)
            flush_q <= flush_q + 16'd1;
         if ((Busy || mul_entry) && mul_q != 16'hFFFF)
            mul_q <= mul_q + 16'd1;
      end
   end

   assign StallCycles = stall_q;
   assign FlushEvents = flush_q;
   assign MulCycles   = mul_q;
`endif

endmodule
